// File: rtl/piece_lock_if.sv
// Request/status bundle between the piece spawner (master) and piece_lock (slave).
interface piece_lock_if;
    logic        lock_req;
    logic [3:0]  piece_x;
    logic [4:0]  piece_y;
    logic [15:0] piece_mask;
    logic        busy;
    logic        lock_done;
    logic        collision;
    logic        update;
    logic        game_over;

    modport master (
        output lock_req, piece_x, piece_y, piece_mask,
        input  busy, lock_done, collision, update, game_over
    );

    modport slave (
        input  lock_req, piece_x, piece_y, piece_mask,
        output busy, lock_done, collision, update, game_over
    );
endinterface

// File: rtl/piece_lock.sv
// Validates a settled tetromino against a board snapshot and merges it in, feeding clear_lines.
// Optional PIECE_COUNT_EN adds the pieces_locked counter port.
module piece_lock #(
    parameter int ROWS = 22,
    parameter int COLS = 12
) (
    input  logic                      vsync,
    input  logic                      reset,
    piece_lock_if.slave               lock_bus,
    input  logic [ROWS-1:0][COLS-1:0] in_row_contents,
`ifdef PIECE_COUNT_EN
    output logic [15:0]               pieces_locked,
`endif
    output logic [ROWS-1:0][COLS-1:0] row_contents
);

    typedef enum logic [2:0] {IDLE, CHECK, MERGE, DONE, FAULT} state_t;

    state_t state, state_next;

    logic [1:0]                row_idx;
    logic                      hit_acc;
    logic [3:0]                snap_x;
    logic [4:0]                snap_y;
    logic [15:0]               snap_mask;
    logic [ROWS-1:0][COLS-1:0] snap;
    logic                      game_over;

    logic                      accept;
    logic [3:0]                mask_row;
    logic [19:0]               shifted;
    logic [5:0]                cell_y;
    logic [COLS-1:0]           board_row;
    logic                      row_valid;
    logic                      row_hit;
    logic [ROWS-1:0][COLS-1:0] merged;

    logic busy, update, lock_done, collision;

    assign accept = (state == IDLE) && lock_bus.lock_req && !game_over;

    // The current mask row is shifted into board columns once; anything landing above
    // COLS-1 or on a row outside the board is a collision, as is overlap with the snapshot.
    always_comb begin
        mask_row  = snap_mask[{row_idx, 2'b00} +: 4];
        shifted   = 20'(mask_row) << snap_x;
        cell_y    = 6'(snap_y) + 6'(row_idx);
        board_row = '0;
        row_valid = 1'b0;
        merged    = snap;
        for (int i = 0; i < ROWS; i++) begin
            if (cell_y == 6'(i)) begin
                board_row = snap[i];
                row_valid = 1'b1;
                merged[i] = snap[i] | shifted[COLS-1:0];
            end
        end
        row_hit = (mask_row != 4'd0) &&
                  (!row_valid || (shifted[19:COLS] != '0) ||
                   ((shifted[COLS-1:0] & board_row) != '0));
    end

    always_ff @(posedge vsync) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        update     = 1'b0;
        lock_done  = 1'b0;
        collision  = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (accept) state_next = CHECK;
            end
            CHECK: begin
                if (row_idx == 2'd3) state_next = (hit_acc || row_hit) ? FAULT : MERGE;
            end
            MERGE: begin
                if (row_idx == 2'd3) state_next = DONE;
            end
            DONE: begin
                update     = 1'b1;
                lock_done  = 1'b1;
                state_next = IDLE;
            end
            FAULT: begin
                lock_done  = 1'b1;
                collision  = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // row_contents tracks the live board only in IDLE; otherwise it holds the snapshot
    // and is loaded with the merged image on the edge that enters DONE.
    always_ff @(posedge vsync) begin
        if (reset) begin
            row_idx      <= 2'd0;
            hit_acc      <= 1'b0;
            snap_x       <= 4'd0;
            snap_y       <= 5'd0;
            snap_mask    <= 16'd0;
            snap         <= '0;
            row_contents <= '0;
            game_over    <= 1'b0;
`ifdef PIECE_COUNT_EN
            pieces_locked <= 16'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    row_contents <= in_row_contents;
                    row_idx      <= 2'd0;
                    hit_acc      <= 1'b0;
                    if (accept) begin
                        snap      <= in_row_contents;
                        snap_x    <= lock_bus.piece_x;
                        snap_y    <= lock_bus.piece_y;
                        snap_mask <= lock_bus.piece_mask;
                    end
                end
                CHECK: begin
                    hit_acc <= hit_acc | row_hit;
                    row_idx <= row_idx + 2'd1;
                    if (row_idx == 2'd3 && (hit_acc || row_hit)) game_over <= 1'b1;
                end
                MERGE: begin
                    snap    <= merged;
                    row_idx <= row_idx + 2'd1;
                    if (row_idx == 2'd3) row_contents <= merged;
                end
                DONE: begin
`ifdef PIECE_COUNT_EN
                    pieces_locked <= pieces_locked + 16'd1;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    assign lock_bus.busy      = busy;
    assign lock_bus.update    = update;
    assign lock_bus.lock_done = lock_done;
    assign lock_bus.collision = collision;
    assign lock_bus.game_over = game_over;

endmodule

// File: tb/tb_piece_lock.sv
// Self-checking bench for piece_lock: directed vector table, corner sequences and random locks
// against a cell-by-cell reference model.
module tb_piece_lock;
    localparam int ROWS = 22;
    localparam int COLS = 12;

    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    typedef struct {
        string       name;
        int          fill_row;
        logic [11:0] fill_val;
        logic [3:0]  x;
        logic [4:0]  y;
        logic [15:0] mask;
        bit          exp_fit;
        int          chk_row;
        logic [11:0] chk_val;
    } vec_t;

    logic   vsync = 1'b0;
    logic   reset;
    board_t in_rows;
    board_t rows_out;
`ifdef PIECE_COUNT_EN
    logic [15:0] pieces_locked;
`endif

    piece_lock_if bus();

    piece_lock #(.ROWS(ROWS), .COLS(COLS)) dut (
        .vsync          (vsync),
        .reset          (reset),
        .lock_bus       (bus),
        .in_row_contents(in_rows),
`ifdef PIECE_COUNT_EN
        .pieces_locked  (pieces_locked),
`endif
        .row_contents   (rows_out)
    );

    always #5 vsync = ~vsync;

    int checks = 0;
    int passes = 0;
    int exp_count = 0;

    int     obs_done_at, obs_update_at, obs_update_cnt, obs_busy_drop_at;
    bit     obs_coll, obs_busy_rise, obs_stable;
    board_t obs_rows;

    vec_t vecs[10];

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge vsync);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic checkBoard(input string name, input board_t actual, input board_t expected);
        int bad;
        bad = -1;
        checks++;
        for (int i = ROWS - 1; i >= 0; i--)
            if (actual[i] !== expected[i]) bad = i;
        if (bad < 0) passes++;
        else $display("[TB] FAIL %s: row %0d got 0x%03h, expected 0x%03h",
                      name, bad, actual[bad], expected[bad]);
    endtask

    function automatic board_t empty_board();
        board_t b;
        b = '0;
        b[0] = '1;
        b[ROWS-1] = '1;
        return b;
    endfunction

    // Reference: walk every set cell of the 4x4 mask, reject on out-of-range or overlap.
    function automatic bit model_lock(input board_t board, input int x, input int y,
                                      input logic [15:0] mask, output board_t result);
        bit fits;
        fits = 1'b1;
        result = board;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (mask[r*4+c]) begin
                    if (y + r > ROWS - 1 || x + c > COLS - 1) fits = 1'b0;
                    else if (board[y+r][x+c]) fits = 1'b0;
                end
        if (fits)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    if (mask[r*4+c]) result[y+r][x+c] = 1'b1;
        return fits;
    endfunction

    task automatic do_reset(input bit verify);
        reset = 1'b1;
        bus.lock_req = 1'b0;
        tick();
        if (verify) begin
            checkOutput("rst_busy", bus.busy, 0);
            checkOutput("rst_update", bus.update, 0);
            checkOutput("rst_lock_done", bus.lock_done, 0);
            checkOutput("rst_collision", bus.collision, 0);
            checkOutput("rst_game_over", bus.game_over, 0);
            checkBoard("rst_rows", rows_out, '0);
`ifdef PIECE_COUNT_EN
            checkOutput("rst_pieces_locked", pieces_locked, 0);
`endif
        end
        reset = 1'b0;
        exp_count = 0;
    endtask

    // One-cycle request, then observe 13 cycles with inputs scrambled to show they are ignored.
    task automatic applyStimulus(input logic [3:0] x, input logic [4:0] y, input logic [15:0] mask);
        board_t start_rows;
        bus.piece_x = x;
        bus.piece_y = y;
        bus.piece_mask = mask;
        bus.lock_req = 1'b1;
        start_rows = in_rows;
        tick();
        bus.lock_req = 1'b0;
        bus.piece_x = ~x;
        bus.piece_y = ~y;
        bus.piece_mask = ~mask;
        in_rows = ~start_rows;
        obs_busy_rise = bus.busy;
        obs_done_at = -1;
        obs_update_at = -1;
        obs_update_cnt = 0;
        obs_busy_drop_at = -1;
        obs_coll = 1'b0;
        obs_stable = 1'b1;
        obs_rows = '0;
        for (int k = 0; k <= 12; k++) begin
            if (bus.lock_done && obs_done_at < 0) begin
                obs_done_at = k;
                obs_coll = bus.collision;
                obs_rows = rows_out;
            end
            if (bus.update) begin
                obs_update_cnt++;
                if (obs_update_at < 0) obs_update_at = k;
            end
            if (!bus.busy && obs_busy_drop_at < 0) obs_busy_drop_at = k;
            if (bus.busy && !bus.lock_done && rows_out !== start_rows) obs_stable = 1'b0;
            tick();
        end
        in_rows = start_rows;
    endtask

    task automatic checkLock(input string name, input bit exp_fit, input board_t exp_rows);
        checkOutput({name, ":busy_rise"}, obs_busy_rise, 1);
        checkOutput({name, ":done_at"}, obs_done_at, exp_fit ? 8 : 4);
        checkOutput({name, ":collision"}, obs_coll, exp_fit ? 0 : 1);
        checkOutput({name, ":update_at"}, obs_update_at, exp_fit ? 8 : -1);
        checkOutput({name, ":update_cnt"}, obs_update_cnt, exp_fit ? 1 : 0);
        checkOutput({name, ":busy_drop"}, obs_busy_drop_at, exp_fit ? 9 : 5);
        checkOutput({name, ":rows_stable"}, obs_stable, 1);
        checkBoard({name, ":rows"}, obs_rows, exp_rows);
        checkOutput({name, ":game_over"}, bus.game_over, exp_fit ? 0 : 1);
        if (exp_fit) exp_count++;
`ifdef PIECE_COUNT_EN
        checkOutput({name, ":pieces_locked"}, pieces_locked, exp_count & 16'hFFFF);
`endif
    endtask

    initial begin
        board_t      board, expect_b, pattern;
        bit          fit, seen;
        logic [15:0] shapes[8];

        vecs[0] = '{"o_empty",     -1, 12'h000, 4'd4,  5'd19, 16'h0033, 1'b1, 20, 12'h030};
        vecs[1] = '{"o_fill_row",  20, 12'hFCF, 4'd4,  5'd19, 16'h0033, 1'b1, 20, 12'hFFF};
        vecs[2] = '{"i_off_right", -1, 12'h000, 4'd9,  5'd5,  16'h000F, 1'b0, 5,  12'h000};
        vecs[3] = '{"overlap",     10, 12'h010, 4'd4,  5'd10, 16'h0001, 1'b0, 10, 12'h010};
        vecs[4] = '{"zero_mask",   -1, 12'h000, 4'd0,  5'd0,  16'h0000, 1'b1, 0,  12'hFFF};
        vecs[5] = '{"ceiling",     -1, 12'h000, 4'd3,  5'd0,  16'h0001, 1'b0, 0,  12'hFFF};
        vecs[6] = '{"floor",       -1, 12'h000, 4'd4,  5'd20, 16'h0033, 1'b0, 20, 12'h000};
        vecs[7] = '{"below_floor", -1, 12'h000, 4'd0,  5'd19, 16'h1000, 1'b0, 19, 12'h000};
        vecs[8] = '{"right_edge",  -1, 12'h000, 4'd8,  5'd1,  16'h000F, 1'b1, 1,  12'hF00};
        vecs[9] = '{"x15",         -1, 12'h000, 4'd15, 5'd3,  16'h0001, 1'b0, 3,  12'h000};

        shapes[0] = 16'h0033; shapes[1] = 16'h000F; shapes[2] = 16'h1111; shapes[3] = 16'h0027;
        shapes[4] = 16'h0063; shapes[5] = 16'h0036; shapes[6] = 16'h0017; shapes[7] = 16'h0071;

        reset = 1'b1;
        bus.lock_req = 1'b0;
        bus.piece_x = '0;
        bus.piece_y = '0;
        bus.piece_mask = '0;
        in_rows = empty_board();
        tick();
        do_reset(1'b1);

        // IDLE tracking lags in_row_contents by one edge.
        for (int i = 0; i < ROWS; i++) pattern[i] = 12'(i * 12'h15B + 7);
        in_rows = pattern;
        checkBoard("idle_lag_before", rows_out, '0);
        tick();
        checkBoard("idle_lag_after", rows_out, pattern);

        for (int v = 0; v < 10; v++) begin
            do_reset(1'b0);
            board = empty_board();
            if (vecs[v].fill_row >= 0) board[vecs[v].fill_row] = vecs[v].fill_val;
            in_rows = board;
            fit = model_lock(board, int'(vecs[v].x), int'(vecs[v].y), vecs[v].mask, expect_b);
            applyStimulus(vecs[v].x, vecs[v].y, vecs[v].mask);
            checkOutput({vecs[v].name, ":table_fit"}, obs_coll, vecs[v].exp_fit ? 0 : 1);
            checkOutput({vecs[v].name, ":table_row"}, obs_rows[vecs[v].chk_row], vecs[v].chk_val);
            checkLock(vecs[v].name, fit, expect_b);
        end

        // game_over is sticky and blocks further requests until reset.
        do_reset(1'b0);
        in_rows = empty_board();
        applyStimulus(4'd9, 5'd5, 16'h000F);
        checkLock("go_setup", 1'b0, empty_board());
        bus.lock_req = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (bus.busy) seen = 1'b1;
        end
        bus.lock_req = 1'b0;
        checkOutput("go_ignore_busy", seen, 0);
        checkOutput("go_sticky", bus.game_over, 1);
        do_reset(1'b0);
        checkOutput("go_cleared", bus.game_over, 0);

        // Reset in MERGE aborts with no update pulse.
        in_rows = empty_board();
        bus.piece_x = 4'd4; bus.piece_y = 5'd19; bus.piece_mask = 16'h0033;
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        checkOutput("merge_rst_busy", bus.busy, 0);
        checkOutput("merge_rst_update", bus.update, 0);
        checkOutput("merge_rst_lock_done", bus.lock_done, 0);
        checkOutput("merge_rst_game_over", bus.game_over, 0);
        checkBoard("merge_rst_rows", rows_out, '0);
        reset = 1'b0;
        exp_count = 0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.update || bus.lock_done) seen = 1'b1;
        end
        checkOutput("merge_rst_no_update", seen, 0);

        // Reset in FAULT clears game_over.
        do_reset(1'b0);
        in_rows = empty_board();
        bus.piece_x = 4'd3; bus.piece_y = 5'd0; bus.piece_mask = 16'h0001;
        bus.lock_req = 1'b1;
        tick();
        bus.lock_req = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        checkOutput("fault_collision", bus.collision, 1);
        reset = 1'b1;
        tick();
        checkOutput("fault_rst_lock_done", bus.lock_done, 0);
        checkOutput("fault_rst_game_over", bus.game_over, 0);
        reset = 1'b0;

        // Held lock_req re-triggers on the first IDLE edge.
        do_reset(1'b0);
        in_rows = empty_board();
        bus.piece_x = 4'd0; bus.piece_y = 5'd0; bus.piece_mask = 16'h0000;
        bus.lock_req = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) tick();
        checkOutput("hold_idle_gap", bus.busy, 0);
        tick();
        checkOutput("hold_retrigger", bus.busy, 1);
        bus.lock_req = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        exp_count = 2;
`ifdef PIECE_COUNT_EN
        checkOutput("hold_pieces_locked", pieces_locked, 2);
`endif

        // Three accepted locks and one rejected one.
        do_reset(1'b0);
        board = empty_board();
        for (int i = 0; i < 3; i++) begin
            in_rows = board;
            fit = model_lock(board, i * 4, 19, 16'h0033, expect_b);
            applyStimulus(4'(i * 4), 5'd19, 16'h0033);
            checkLock("count_lock", fit, expect_b);
            board = expect_b;
        end
        in_rows = board;
        fit = model_lock(board, 0, 19, 16'h0033, expect_b);
        applyStimulus(4'd0, 5'd19, 16'h0033);
        checkLock("count_fault", fit, expect_b);
`ifdef PIECE_COUNT_EN
        checkOutput("count_total", pieces_locked, 3);
`endif

        // Random boards and pieces against the reference model.
        do_reset(1'b0);
        for (int n = 0; n < 60; n++) begin
            logic [3:0]  rx;
            logic [4:0]  ry;
            logic [15:0] rm;
            board = empty_board();
            for (int i = 1; i < ROWS - 1; i++)
                board[i] = 12'($urandom & $urandom & $urandom);
            rx = 4'($urandom_range(0, 15));
            ry = 5'($urandom_range(0, 23));
            rm = ($urandom_range(0, 4) == 0) ? 16'($urandom) : shapes[$urandom_range(0, 7)];
            in_rows = board;
            fit = model_lock(board, int'(rx), int'(ry), rm, expect_b);
            applyStimulus(rx, ry, rm);
            checkLock("random", fit, expect_b);
            if (!fit) do_reset(1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/piece_lock.md
# piece_lock

Upstream stage of `clear_lines`.
- Takes the settled tetromino (4×4 mask plus board position) and validates it against the current 22×12 playfield.
- If it fits, ORs it into the board, then pulses `update` so `clear_lines` removes completed rows on the same board image.
- A failed placement sets a sticky `game_over` and leaves the board unchanged.

## Interface
Parameters:
- `ROWS`, 22, board rows; row 0 = ceiling, row ROWS-1 = floor, both all-ones.
- `COLS`, 12, board columns; column k = bit k of a row word.

Ports:
- `vsync`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `lock_req`  in  1  request to lock the current piece; sampled only in IDLE.
- `piece_x`  in  4  board column of mask column 0.
- `piece_y`  in  5  board row of mask row 0.
- `piece_mask`  in  16  shape; bit r*4+c = mask row r, column c.
- `in_row_contents`  in  [11:0]×ROWS  current board.
- `row_contents`  out  [11:0]×ROWS  registered board to `clear_lines`.
- `update`  out  1  one-cycle pulse; merged board is valid on `row_contents`.
- `busy`  out  1  high outside IDLE.
- `lock_done`  out  1  one-cycle pulse at the end of every accepted request.
- `collision`  out  1  valid with `lock_done`; 1 = piece rejected.
- `game_over`  out  1  sticky; set on any collision.
- `pieces_locked`  out  16  present only with PIECE_COUNT_EN.

## Operation
States:
- IDLE
  - `row_contents` follows `in_row_contents` with a one-cycle lag.
  - `lock_req`=1 with `game_over`=0 → latch `piece_x`, `piece_y`, `piece_mask` and `in_row_contents` into a snapshot; row index r=0; go to CHECK.
- CHECK, 4 cycles, one mask row r per cycle. A set cell (r,c) is a collision if any of these holds:
  - `piece_y`+r > ROWS-1 (6-bit sum, no wrap);
  - `piece_x`+c > COLS-1 (5-bit sum);
  - the snapshot bit at that cell is already 1.
  - Collisions accumulate. After r=3: any collision → FAULT, else MERGE with r=0.
- MERGE, 4 cycles: OR mask row r into snapshot row `piece_y`+r, bits `piece_x`..`piece_x`+3. Zero mask rows modify nothing. After r=3 → DONE.
- DONE, 1 cycle: `row_contents` = snapshot; `update`=1; `lock_done`=1; `collision`=0; counter +1. Next → IDLE.
- FAULT, 1 cycle: `row_contents` = unmodified snapshot; `lock_done`=1; `collision`=1; `game_over` set; `update`=0. Next → IDLE.

Rules:
- Inputs are ignored while `busy`=1; a held `lock_req` re-triggers on return to IDLE.
- When `game_over`=1, `lock_req` is ignored until `reset`.
- An all-zero mask passes CHECK and still pulses `update` with the board unchanged.
- Ceiling and floor rows are full, so overlap with them counts as a collision.

## Timing
Reset values:
- state IDLE;
- `row_contents` all zero;
- `update`, `busy`, `lock_done`, `collision`, `game_over` all 0;
- `pieces_locked` 0.

Latency, with acceptance at edge N:
- `busy` rises after edge N.
- Success: `update` and `lock_done` are high for the cycle after edge N+8. `busy` drops after edge N+9.
- Collision: `lock_done` and `collision` are high for the cycle after edge N+4.

Other timing rules:
- `row_contents` is stable from acceptance through DONE/FAULT. It resumes tracking `in_row_contents` one cycle after returning to IDLE.
- Reset at any state, including DONE/FAULT, aborts without an `update` pulse and clears `game_over`.
- Counter wraps FFFF→0000.

## Configuration
- `PIECE_COUNT_EN` defined: `pieces_locked` port exists. It increments once per DONE and is unchanged by FAULT.
- Not defined: port and counter are absent. All other behaviour is identical.

## Test plan
- Empty board (rows 1–20 = 0), O-piece mask 0x0033, x=4, y=19, `lock_req` one cycle → `update` 8 cycles after acceptance; rows 19/20 = 0x030; `collision`=0.
- Row 20 = 0xFCF, same O-piece at x=4, y=19 → row 20 = 0xFFF and `update` pulses. Feeding that board through `clear_lines` removes row 20.
- I-piece 0x000F at x=9, y=5 → column 12 is out of range; `lock_done`+`collision` at N+4; `game_over`=1; board unchanged; later `lock_req` ignored.
- Piece overlapping occupied cell (row 10 = 0x010, mask 0x0001, x=4, y=10) → FAULT; no `update`.
- `reset` asserted during MERGE → next cycle all outputs at reset values; no `update`; `game_over`=0.
- With PIECE_COUNT_EN: 3 successful locks plus 1 collision → `pieces_locked`=3.
